// File: rtl/sample_frame_loader.sv
// Serial-to-parallel frame loader: packs LANES signed samples into one frame held under valid/ready.
// Define SFL_SUM_EN to build the running frame-sum accumulator; otherwise out_sum is tied to zero.
module sample_frame_loader #(
  parameter int DATAWIDTH = 16,
  parameter int LANES     = 8,
  parameter int CNTWIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATAWIDTH-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANES*DATAWIDTH-1:0]   out_lanes,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*DATAWIDTH-1:0]       out_sum,
  output logic [CNTWIDTH-1:0]          frame_cnt
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            accept;
  logic            last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);

  // in_ready/out_valid are registered alongside state so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      out_lanes <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      frame_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int unsigned k = 0; k < LANES; k++) begin
              if (idx == IDXW'(k))
                out_lanes[k*DATAWIDTH +: DATAWIDTH] <= in_data;
            end
            if (last) begin
              state     <= FULL;
              idx       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef SFL_SUM_EN
  logic signed [2*DATAWIDTH-1:0] acc;
  logic signed [2*DATAWIDTH-1:0] sample_ext;

  assign sample_ext = {{DATAWIDTH{in_data[DATAWIDTH-1]}}, in_data};

  // The first sample of a frame restarts the sum instead of adding to the previous frame's total.
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (accept)
      acc <= ((idx == '0) ? '0 : acc) + sample_ext;
  end

  assign out_sum = acc;
`else
  assign out_sum = '0;
`endif

endmodule

// File: tb/tb_sample_frame_loader.sv
// Bench for sample_frame_loader: directed and randomized steps against a frame-level reference model.
module tb_sample_frame_loader;
  localparam int DW = 16;
  localparam int L  = 8;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [L*DW-1:0]  out_lanes;
  logic             out_valid;
  logic             out_ready;
  logic [2*DW-1:0]  out_sum;
  logic [CW-1:0]    frame_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: samples collected so far in the current frame, last lane contents, totals.
  logic [DW-1:0] m_lanes [L];
  int            m_fill;
  bit            m_full;
  longint        m_sum;
  int unsigned   m_cnt;
  int unsigned   handoffs;
  bit            saw_wrap;

  sample_frame_loader #(.DATAWIDTH(DW), .LANES(L), .CNTWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_lanes(out_lanes), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [L*DW-1:0] model_bus();
    logic [L*DW-1:0] b;
    for (int k = 0; k < L; k++) b[k*DW +: DW] = m_lanes[k];
    return b;
  endfunction

  // Advance the model with the inputs present before the edge, clock once, then compare.
  task automatic tick();
    if (rst) begin
      m_full = 0; m_fill = 0; m_sum = 0; m_cnt = 0;
      for (int k = 0; k < L; k++) m_lanes[k] = '0;
    end else if (!m_full) begin
      if (in_valid) begin
        m_lanes[m_fill] = in_data;
        m_sum = (m_fill == 0 ? 0 : m_sum) + longint'($signed(in_data));
        m_fill++;
        if (m_fill == L) begin m_full = 1; m_fill = 0; end
      end
    end else if (out_ready) begin
      m_full = 0;
      if (m_cnt == 255) saw_wrap = 1;
      m_cnt = (m_cnt + 1) % 256;
      handoffs++;
    end
    @(posedge clk);
    #1;
    chk("in_ready", 128'(in_ready), 128'(!m_full));
    chk("out_valid", 128'(out_valid), 128'(m_full));
    chk("frame_cnt", 128'(frame_cnt), 128'(m_cnt));
    chk("out_lanes", 128'(out_lanes), 128'(model_bus()));
`ifdef SFL_SUM_EN
    if (m_full) chk("out_sum", 128'(out_sum), 128'(32'(m_sum)));
`else
    chk("out_sum_zero", 128'(out_sum), 128'd0);
`endif
  endtask

  task automatic push_frame(input int base, input int step, input bit hold);
    out_ready = ~hold;
    for (int i = 0; i < L; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i * step);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    bit     accepted;
    int     cycles;
    logic [DW-1:0] v;

    saw_wrap = 0; handoffs = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("reset_lanes", 128'(out_lanes), 128'd0);
    chk("reset_sum", 128'(out_sum), 128'd0);
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    tick();

    // Straight fill 1..8 with consumer ready.
    push_frame(1, 1, 1'b0);
    chk("fill_lane7", 128'(out_lanes[7*DW +: DW]), 128'd8);
`ifdef SFL_SUM_EN
    chk("fill_sum36", 128'(out_sum), 128'd36);
`endif
    tick();
    chk("fill_cnt1", 128'(frame_cnt), 128'd1);
    chk("fill_ready_back", 128'(in_ready), 128'd1);

    // Backpressure: full frame held while producer keeps offering 9.
    push_frame(20, 1, 1'b1);
    in_valid = 1'b1; in_data = DW'(9);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp_lane0_9", 128'(out_lanes[DW-1:0]), 128'd9);
    for (int i = 1; i < L; i++) begin
      in_valid = 1'b1; in_data = DW'(100 + i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Signed extremes.
    push_frame(-32768, 0, 1'b1);
`ifdef SFL_SUM_EN
    chk("sum_min", 128'(out_sum), 128'(32'(-262144)));
`endif
    out_ready = 1'b1; tick();
    push_frame(32767, 0, 1'b1);
`ifdef SFL_SUM_EN
    chk("sum_max", 128'(out_sum), 128'd262136);
`endif
    out_ready = 1'b1; tick();

    // Reset in the middle of a frame.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'(50 + i); tick();
    end
    in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    push_frame(10, 1, 1'b1);
    chk("midrst_lane0", 128'(out_lanes[DW-1:0]), 128'd10);
`ifdef SFL_SUM_EN
    chk("midrst_sum108", 128'(out_sum), 128'd108);
`endif
    chk("midrst_cnt0", 128'(frame_cnt), 128'd0);

    // Randomized traffic through at least one counter wrap.
    v = DW'($urandom);
    accepted = 0;
    cycles = 0;
    handoffs = 0;
    while (handoffs < 270 && cycles < 20000) begin
      if (accepted) v = DW'($urandom);
      in_data   = v;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      accepted  = in_valid && !m_full;
      tick();
      cycles++;
    end
    chk("random_budget", 128'(cycles < 20000), 128'd1);
    chk("wrap_seen", 128'(saw_wrap), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
